// File: rtl/viterbi_decoder.sv
// ---------------------------------------------------------------------------
// viterbi_decoder
//   Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code
//   (G0 = 111 for p0, G1 = 101 for p1). The serial code stream arrives one
//   bit per accepted cycle as p0, p1, p0, p1, ... Add-compare-select runs over
//   4 states on every p1 edge. Survivors use register exchange. One decoded
//   bit is emitted per pair after DEPTH pairs of latency.
//
// Ports:
//   clock       in   rising-edge system clock
//   reset       in   asynchronous active-low reset
//   in_valid    in   qualifies `in` this cycle
//   in          in   serial code bit
//   out         out  decoded data bit (meaningful when out_valid=1)
//   out_valid   out  one-cycle pulse qualifying `out`
//   best_state  out  minimum-metric state after the most recent ACS
//
// Handshake: in_valid/in is accepted unconditionally on every rising edge
//   where in_valid=1. There is no backpressure, and out_valid is a one-cycle
//   pulse that the consumer must take on the cycle it appears.
//
// Optional build macro:
//   VITERBI_PM_NORM_EN  defined   -> when all four new path metrics have the
//                                    MSB set, the MSB is cleared on every one.
//                       undefined -> each new metric saturates at 2^PM_W-1.
//
// Parameter range: DEPTH 4..32, PM_W >= 4.
// ---------------------------------------------------------------------------
module viterbi_decoder #(
  parameter logic [2:0] G0    = 3'b111,
  parameter logic [2:0] G1    = 3'b101,
  parameter int         DEPTH = 16,
  parameter int         PM_W  = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in,
  output logic       out,
  output logic       out_valid,
  output logic [1:0] best_state
);

  localparam int                CNT_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  FILL_MAX = CNT_W'(DEPTH - 1);
  localparam logic [PM_W-1:0]   PM_INIT  = PM_W'(8);
  localparam logic [PM_W:0]     PM_TOP   = {1'b0, {PM_W{1'b1}}};
`ifdef VITERBI_PM_NORM_EN
  localparam logic [PM_W-1:0]   PM_HALF  = {1'b1, {(PM_W-1){1'b0}}};
`endif

  // Phase FSM: which half of the code pair the next accepted bit is.
  typedef enum logic {PH_P0 = 1'b0, PH_P1 = 1'b1} phase_t;

  phase_t           r_phase;
  phase_t           w_phase_next;
  logic             r_p0;
  logic [PM_W-1:0]  r_pm [4];
  // The oldest survivor bit is only ever needed combinationally for the
  // output decision, so the stored survivor drops it.
  logic [DEPTH-2:0] r_sv [4];
  logic [CNT_W-1:0] r_fill;
  logic             r_out;
  logic             r_out_valid;
  logic [1:0]       r_best;

  logic             w_pair_fire;
  logic [PM_W:0]    w_cand0 [4];
  logic [PM_W:0]    w_cand1 [4];
  logic [PM_W:0]    w_sel   [4];
  logic             w_take1 [4];
  logic [PM_W-1:0]  w_sat   [4];
  logic [PM_W-1:0]  w_pm_new[4];
  logic [DEPTH-1:0] w_sv_new[4];
  logic [1:0]       w_best;
  logic             w_out;
`ifdef VITERBI_PM_NORM_EN
  logic             w_all_hi;
`endif

  // Hamming distance between the received pair and the pair the encoder
  // would emit from state s on input u (taps {u, s[1], s[0]}).
  function automatic logic [1:0] branch_metric(input logic [1:0] s,
                                               input logic       u,
                                               input logic       r0,
                                               input logic       r1);
    logic [2:0] taps;
    logic       e0;
    logic       e1;
    taps = {u, s};
    e0   = ^(G0 & taps);
    e1   = ^(G1 & taps);
    branch_metric = {1'b0, r0 ^ e0} + {1'b0, r1 ^ e1};
  endfunction

  assign w_pair_fire = in_valid && (r_phase == PH_P1);

  // Phase FSM next state.
  always_comb begin
    w_phase_next = r_phase;
    if (in_valid) begin
      w_phase_next = (r_phase == PH_P0) ? PH_P1 : PH_P0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase <= PH_P0;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // ACS: next state ns = {u, a} has predecessors {a,0} and {a,1}. Candidates
  // are one bit wider than the metric so the compare sees the true sum even
  // when a predecessor metric sits at the top of its range. A tie keeps the
  // predecessor with LSB 0.
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      w_cand0[ns]  = {1'b0, r_pm[{ns[0], 1'b0}]}
                   + (PM_W+1)'(branch_metric({ns[0], 1'b0}, ns[1], r_p0, in));
      w_cand1[ns]  = {1'b0, r_pm[{ns[0], 1'b1}]}
                   + (PM_W+1)'(branch_metric({ns[0], 1'b1}, ns[1], r_p0, in));
      w_take1[ns]  = (w_cand1[ns] < w_cand0[ns]);
      w_sel[ns]    = w_take1[ns] ? w_cand1[ns] : w_cand0[ns];
      w_sat[ns]    = (w_sel[ns] > PM_TOP) ? PM_TOP[PM_W-1:0] : w_sel[ns][PM_W-1:0];
      w_sv_new[ns] = {r_sv[{ns[0], w_take1[ns]}], ns[1]};
    end
  end

`ifdef VITERBI_PM_NORM_EN
  // With normalization the metric spread stays far below 2^(PM_W-1), so the
  // saturation above never engages and clearing the common MSB is exact.
  always_comb begin
    w_all_hi = 1'b1;
    for (int ns = 0; ns < 4; ns++) begin
      if (!w_sat[ns][PM_W-1]) w_all_hi = 1'b0;
    end
    for (int ns = 0; ns < 4; ns++) begin
      w_pm_new[ns] = w_all_hi ? (w_sat[ns] & ~PM_HALF) : w_sat[ns];
    end
  end
`else
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      w_pm_new[ns] = w_sat[ns];
    end
  end
`endif

  // Minimum new metric, lowest index wins a tie.
  always_comb begin
    w_best = 2'd0;
    for (int ns = 1; ns < 4; ns++) begin
      if (w_pm_new[ns] < w_pm_new[w_best]) w_best = 2'(ns);
    end
  end

  assign w_out = w_sv_new[w_best][DEPTH-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p0        <= 1'b0;
      r_fill      <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_best      <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_pm[i] <= (i == 0) ? '0 : PM_INIT;
        r_sv[i] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid && (r_phase == PH_P0)) begin
        r_p0 <= in;
      end
      if (w_pair_fire) begin
        for (int i = 0; i < 4; i++) begin
          r_pm[i] <= w_pm_new[i];
          r_sv[i] <= w_sv_new[i][DEPTH-2:0];
        end
        r_best <= w_best;
        if (r_fill == FILL_MAX) begin
          r_out_valid <= 1'b1;
          r_out       <= w_out;
        end else begin
          r_fill <= r_fill + CNT_W'(1);
        end
      end
    end
  end

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign best_state = r_best;

endmodule

// File: tb/tb_viterbi_decoder.sv
// ---------------------------------------------------------------------------
// tb_viterbi_decoder
//   Two decoder instances share one input stream: dut_a (DEPTH=4, PM_W=6)
//   and dut_b (DEPTH=8, PM_W=4). A reference model tracks full path
//   histories as plain arrays and integer metrics, and every cycle the DUT
//   outputs and metrics are compared against it. Directed scenarios also
//   carry hand-derived expected bits in a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_viterbi_decoder;

  localparam logic [2:0] G0   = 3'b111;
  localparam logic [2:0] G1   = 3'b101;
  localparam int         DA   = 4;
  localparam int         WA   = 6;
  localparam int         DB   = 8;
  localparam int         WB   = 4;
  localparam int         MAXP = 512;

  // ---------------- clock / reset ----------------
  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit   = 1'b0;

  logic       out_a, ov_a, out_b, ov_b;
  logic [1:0] bs_a, bs_b;

  always #5 clock = ~clock;

  viterbi_decoder #(.G0(G0), .G1(G1), .DEPTH(DA), .PM_W(WA)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in_bit),
    .out(out_a), .out_valid(ov_a), .best_state(bs_a)
  );

  viterbi_decoder #(.G0(G0), .G1(G1), .DEPTH(DB), .PM_W(WB)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in_bit),
    .out(out_b), .out_valid(ov_b), .best_state(bs_b)
  );

  // ---------------- bookkeeping ----------------
  int n_assert = 0;
  int n_fail   = 0;

  logic [0:0] exp_q[$];
  bit         sb_on   = 1'b0;
  bit         zero_on = 1'b0;

  // ---------------- reference model ----------------
  int m_depth[2];
  int m_pmw[2];
  int m_pm[2][4];
  bit m_path[2][4][MAXP];
  bit m_tmp[4][MAXP];
  int m_best[2];
  bit m_ov[2];
  bit m_out[2];
  int m_pairs;
  bit m_phase;
  bit m_held;

  function automatic void encode(input int s, input int u, output bit e0, output bit e1);
    int taps;
    taps = u * 4 + s;
    e0 = 1'b0;
    e1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (G0[i] && taps[i]) e0 = ~e0;
      if (G1[i] && taps[i]) e1 = ~e1;
    end
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pm[m][0] = 0;
      m_pm[m][1] = 8;
      m_pm[m][2] = 8;
      m_pm[m][3] = 8;
      m_best[m]  = 0;
      m_ov[m]    = 1'b0;
      m_out[m]   = 1'b0;
    end
    m_pairs = 0;
    m_phase = 1'b0;
    m_held  = 1'b0;
  endtask

  task automatic model_pair(input bit r0, input bit r1);
    for (int m = 0; m < 2; m++) begin
      int npm[4];
      int from[4];
      int k;
      int half;
      int top;
      bit e0;
      bit e1;
      int c;
      int nxt;
      k = m_pairs;
      for (int s = 0; s < 4; s++) begin
        npm[s]  = 1 << 30;
        from[s] = 0;
      end
      // Walk every (state, input) branch; the first strictly better
      // candidate wins, so ties fall to the lower-numbered predecessor.
      for (int s = 0; s < 4; s++) begin
        for (int u = 0; u < 2; u++) begin
          nxt = u * 2 + s / 2;
          encode(s, u, e0, e1);
          c = m_pm[m][s] + int'(r0 != e0) + int'(r1 != e1);
          if (c < npm[nxt]) begin
            npm[nxt]  = c;
            from[nxt] = s;
          end
        end
      end
      half = 1 << (m_pmw[m] - 1);
      top  = (1 << m_pmw[m]) - 1;
`ifdef VITERBI_PM_NORM_EN
      if (npm[0] >= half && npm[1] >= half && npm[2] >= half && npm[3] >= half) begin
        for (int s = 0; s < 4; s++) npm[s] = npm[s] - half;
      end
`else
      for (int s = 0; s < 4; s++) if (npm[s] > top) npm[s] = top;
`endif
      for (int s = 0; s < 4; s++) begin
        for (int j = 0; j < k; j++) m_tmp[s][j] = m_path[m][from[s]][j];
        m_tmp[s][k] = (s >= 2);
      end
      for (int s = 0; s < 4; s++) begin
        for (int j = 0; j <= k; j++) m_path[m][s][j] = m_tmp[s][j];
        m_pm[m][s] = npm[s];
      end
      m_best[m] = 0;
      for (int s = 1; s < 4; s++) if (npm[s] < npm[m_best[m]]) m_best[m] = s;
      m_ov[m]  = (k >= m_depth[m] - 1);
      m_out[m] = m_ov[m] ? m_path[m][m_best[m]][k - m_depth[m] + 1] : 1'b0;
    end
    m_pairs = m_pairs + 1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [0:0] e;
    chk({tag, " ov_a"}, ov_a, m_ov[0]);
    chk({tag, " ov_b"}, ov_b, m_ov[1]);
    if (m_ov[0]) chk({tag, " out_a"}, out_a, m_out[0]);
    if (m_ov[1]) chk({tag, " out_b"}, out_b, m_out[1]);
    chk({tag, " best_a"}, bs_a, m_best[0]);
    chk({tag, " best_b"}, bs_b, m_best[1]);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s pm_a[%0d]", tag, i), dut_a.r_pm[i], m_pm[0][i]);
      chk($sformatf("%s pm_b[%0d]", tag, i), dut_b.r_pm[i], m_pm[1][i]);
    end
    if (sb_on && ov_a === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, " sb_extra_out"}, ov_a, 0);
      end else begin
        e = exp_q.pop_front();
        chk({tag, " sb_out"}, out_a, e);
      end
    end
    if (zero_on && ov_a === 1'b1) chk({tag, " zero_a"}, out_a, 0);
    if (zero_on && ov_b === 1'b1) chk({tag, " zero_b"}, out_b, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input bit b, input string tag);
    in_valid = v;
    in_bit   = b;
    @(posedge clock);
    #1;
    m_ov[0] = 1'b0;
    m_ov[1] = 1'b0;
    if (v) begin
      if (!m_phase) begin
        m_held  = b;
        m_phase = 1'b1;
      end else begin
        m_phase = 1'b0;
        model_pair(m_held, b);
      end
    end
    check_outputs(tag);
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, " async"});
    @(posedge clock);
    #1;
    check_outputs({tag, " held"});
    #2;
    reset = 1'b1;
  endtask

  task automatic send_stream(input logic [11:0] st, input bit gaps, input int nbits,
                             input string tag);
    for (int j = 0; j < nbits; j++) begin
      step(1'b1, st[11-j], $sformatf("%s b%0d", tag, j));
      if (gaps && (j % 2 == 0)) step(1'b0, 1'($urandom_range(0, 1)), $sformatf("%s gap%0d", tag, j));
    end
  endtask

  task automatic load_expected();
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
  endtask

  // ---------------- stimulus ----------------
  // Data 1,0,1,1,0,0 encodes to pairs 11 10 00 01 01 11.
  localparam logic [11:0] ST_CLEAN = 12'b1110_0001_0111;
  localparam logic [11:0] ST_FLIP3 = 12'b1111_0001_0111;

  initial begin
    int  enc_s;
    int  u;
    bit  e0;
    bit  e1;

    m_depth[0] = DA; m_depth[1] = DB;
    m_pmw[0]   = WA; m_pmw[1]   = WB;
    model_reset();
    #2;

    // Scenario 1: reset, then idle.
    do_reset("s1 rst");
    for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)), $sformatf("s1 idle%0d", i));

    // Scenario 2: clean stream, continuous valid.
    do_reset("s2 rst");
    load_expected();
    sb_on = 1'b1;
    send_stream(ST_CLEAN, 1'b0, 12, "s2");
    sb_on = 1'b0;
    chk("s2 sb_left", exp_q.size(), 0);
    chk("s2 final_best_a", bs_a, 0);

    // Scenario 3: one channel error on stream bit 3.
    do_reset("s3 rst");
    load_expected();
    sb_on = 1'b1;
    send_stream(ST_FLIP3, 1'b0, 12, "s3");
    sb_on = 1'b0;
    chk("s3 sb_left", exp_q.size(), 0);

    // Scenario 4: idle cycle between p0 and p1 of every pair.
    do_reset("s4 rst");
    load_expected();
    sb_on = 1'b1;
    send_stream(ST_CLEAN, 1'b1, 12, "s4");
    sb_on = 1'b0;
    chk("s4 sb_left", exp_q.size(), 0);

    // Scenario 5: reset while holding the p0 of pair 2, then full replay.
    do_reset("s5 rst0");
    send_stream(ST_CLEAN, 1'b0, 5, "s5pre");
    do_reset("s5 rst1");
    load_expected();
    sb_on = 1'b1;
    send_stream(ST_CLEAN, 1'b0, 12, "s5");
    sb_on = 1'b0;
    chk("s5 sb_left", exp_q.size(), 0);

    // Scenario 6: long all-zero run with every 5th pair received as 11.
    do_reset("s6 rst");
`ifdef VITERBI_PM_NORM_EN
    zero_on = 1'b1;
`endif
    for (int p = 0; p < 200; p++) begin
      step(1'b1, (p % 5 == 4), $sformatf("s6 p%0d a", p));
      step(1'b1, (p % 5 == 4), $sformatf("s6 p%0d b", p));
    end
    zero_on = 1'b0;

    // Random: encoded random data with sparse bit errors and idle gaps.
    do_reset("rnd rst");
    enc_s = 0;
    for (int p = 0; p < 300; p++) begin
      u = int'($urandom_range(0, 1));
      encode(enc_s, u, e0, e1);
      enc_s = u * 2 + enc_s / 2;
      if ($urandom_range(0, 15) == 0) e0 = ~e0;
      if ($urandom_range(0, 15) == 0) e1 = ~e1;
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), $sformatf("rnd p%0d g0", p));
      step(1'b1, e0, $sformatf("rnd p%0d p0", p));
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), $sformatf("rnd p%0d g1", p));
      step(1'b1, e1, $sformatf("rnd p%0d p1", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code produced by the team's encoder.
- Accepts the serial coded stream, one code bit per accepted cycle, alternating p0 then p1.
- Runs add-compare-select (ACS) over 4 states and uses register-exchange survivors.
- Emits one decoded bit per code pair after a fixed decision depth; sits on the receive side of the PRML channel model.

Parameters:
- G0, 3'b111, generator for p0; bit 2 multiplies the newest input u, bit 0 the oldest.
- G1, 3'b101, generator for p1; same bit mapping as G0.
- DEPTH, 16, survivor length in decoded bits; legal range 4..32.
- PM_W, 6, path-metric width in bits; minimum 4.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  qualifies `in` for this cycle.
- in  in  1  serial code bit.
- out  out  1  decoded data bit.
- out_valid  out  1  one-cycle pulse qualifying `out`.
- best_state  out  2  index of the minimum-metric state after the last ACS.

Behaviour:
- Reset (reset==0, async): phase=p0, PM[0]=0, PM[1..3]=8, all survivors 0, fill counter 0, out=0, out_valid=0, best_state=0.
  - Reset during a half-received pair discards the held p0.
- Phase: first in_valid bit after reset is p0, the next is p1, then alternating. Cycles with in_valid=0 change no state and hold phase; out_valid=0 in those cycles.
- On an accepted p0: register the bit; no other update.
- On an accepted p1: a full pair {r0,r1} is present; ACS updates on this same edge.
- State s = {u[n-1],u[n-2]}. Input u moves the state to {u,u[n-1]}.
  - Expected pair for (s,u): e0 = ^(G0 & {u,s}), e1 = ^(G1 & {u,s}).
- Branch metric = Hamming distance({r0,r1},{e0,e1}), range 0..2.
- ACS for next state ns={u,a}: predecessors are {a,0} and {a,1}.
  - Candidate = PM[pred] + BM.
  - Keep the smaller candidate; on a tie, take the predecessor with LSB 0.
- Survivor update: SV[ns] = {SV[pred][DEPTH-2:0], u}.
- Fill counter: increments per pair and saturates at DEPTH-1.
- Decision (same edge as the ACS update): if the counter was already DEPTH-1 before this pair, out_valid=1.
  - out = bit DEPTH-1 of the new survivor of the minimum new-metric state; ties go to the lowest index.
  - The first out_valid is on pair index DEPTH-1 (0-based) and outputs u[0].
  - Latency is DEPTH pairs, constant thereafter; one out bit per pair.
- best_state is updated on every pair.
- Metric overflow handling is governed by the optional feature below.
- No backpressure: the downstream must accept every out_valid pulse.

Optional Feature:
- Macro: VITERBI_PM_NORM_EN.
- Defined: after ACS, if all four new metrics ≥ 2^(PM_W-1), subtract 2^(PM_W-1) from each by clearing the MSB. Metrics never saturate and decisions are exact indefinitely.
- Undefined: each new metric saturates at 2^PM_W-1 with no normalization; long noisy runs may degrade decisions.
- Defined or not, out and out_valid are identical for any input where no metric reaches 2^(PM_W-1).

Test Plan:
1. Reset then idle 20 cycles with in_valid=0 -> out_valid never asserts; best_state=0; PM readback {0,8,8,8}.
2. DEPTH=4, data 1,0,1,1,0,0, stream 1,1,1,0,0,0,0,1,0,1,1,1 with in_valid continuous -> out_valid on pairs 3,4,5 with out=1,0,1; best_state=0 after pair 5.
3. Same as scenario 2 but with bit 3 of the stream flipped (stream 1,1,1,1,…) -> identical out sequence 1,0,1.
4. Same as scenario 2 with in_valid=0 inserted between p0 and p1 of every pair -> identical outputs; out_valid only on p1-accept edges.
5. Assert reset after the p0 of pair 2, release, then replay the full scenario-2 stream -> outputs match scenario 2 exactly, with no residual pair state.
6. PM_W=4, 200 all-zero pairs with every 5th pair flipped to 11 -> with VITERBI_PM_NORM_EN: all out=0 and no metric exceeds 15; without it: metrics saturate at 15 and no X or wraparound appears.
